// File: rtl/enemy_wave_ctrl_if.sv
// Control/status bundle between the game logic and the enemy wave controller.
interface enemy_wave_ctrl_if;
    logic       frame_clk;
    logic       start;
    logic       is_playing;
    logic       hit;
    logic       enemy_direction_X;
    logic       enemy_direction_Y;
    logic       delete_enemies;
    logic [9:0] formation_x;
    logic [9:0] formation_y;
    logic [5:0] enemies_alive;
    logic       wave_cleared;
    logic       game_over;

    // Game side: drives frame timing and events, observes formation state.
    modport master (
        output frame_clk, start, is_playing, hit,
        input  enemy_direction_X, enemy_direction_Y, delete_enemies,
        input  formation_x, formation_y, enemies_alive, wave_cleared, game_over
    );

    // Controller side.
    modport slave (
        input  frame_clk, start, is_playing, hit,
        output enemy_direction_X, enemy_direction_Y, delete_enemies,
        output formation_x, formation_y, enemies_alive, wave_cleared, game_over
    );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Enemy formation controller: marches the formation left/right one pixel per
// frame, drops it at each boundary, counts kills and flags cleared / lost waves.
module enemy_wave_ctrl #(
    parameter int unsigned ENEMY_COUNT = 15,
    parameter int unsigned X_INIT      = 100,
    parameter int unsigned Y_INIT      = 40,
    parameter int unsigned FORMATION_W = 400,
    parameter int unsigned X_MIN       = 8,
    parameter int unsigned X_MAX       = 632,
    parameter int unsigned DROP_FRAMES = 10,
    parameter int unsigned Y_LIMIT     = 380
) (
    input  logic               clk_i,
    input  logic               reset_i,
    enemy_wave_ctrl_if.slave   bus
);
    localparam logic [9:0] X_INIT_C  = 10'(X_INIT);
    localparam logic [9:0] Y_INIT_C  = 10'(Y_INIT);
    localparam logic [9:0] FORM_W_C  = 10'(FORMATION_W);
    localparam logic [9:0] X_MIN_C   = 10'(X_MIN);
    localparam logic [9:0] X_MAX_C   = 10'(X_MAX);
    localparam logic [9:0] DROP_C    = 10'(DROP_FRAMES);
    localparam logic [9:0] Y_LIMIT_C = 10'(Y_LIMIT);
    localparam logic [5:0] COUNT_C   = 6'(ENEMY_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARCH,
        S_DROP,
        S_CLEARED,
        S_OVER
    } state_t;

    state_t     state_q;
    logic       fsync1_q, fsync2_q, fprev_q;
    logic [9:0] x_q, y_q, drop_cnt_q;
    logic [5:0] alive_q;
    logic       dir_x_q, dir_y_q, del_q, clr_q, over_q;

    logic       tick;
    logic [9:0] x_d, y_d, cnt_d;
    logic [5:0] alive_d;
    logic       at_edge;

    // Frame tick: one cycle after the synchronised rising edge; dropped while paused.
    assign tick = fsync2_q & ~fprev_q & bus.is_playing;

    // Candidate next values; the FSM decides which of them are committed.
    always_comb begin
        x_d     = dir_x_q ? (x_q + 10'd1) : (x_q - 10'd1);
        y_d     = y_q + 10'd1;
        cnt_d   = drop_cnt_q - 10'd1;
        alive_d = (bus.hit && alive_q != 6'd0) ? (alive_q - 6'd1) : alive_q;
        at_edge = dir_x_q ? ((x_d + FORM_W_C) == X_MAX_C) : (x_d == X_MIN_C);
    end

    // Synchroniser plus wave FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsync1_q   <= 1'b0;
            fsync2_q   <= 1'b0;
            fprev_q    <= 1'b0;
            state_q    <= S_IDLE;
            x_q        <= X_INIT_C;
            y_q        <= Y_INIT_C;
            alive_q    <= COUNT_C;
            drop_cnt_q <= 10'd0;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b0;
            del_q      <= 1'b0;
            clr_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            fsync1_q <= bus.frame_clk;
            fsync2_q <= fsync1_q;
            fprev_q  <= fsync2_q;
            del_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_CLEARED, S_OVER: begin
                    if (bus.start) begin
                        state_q <= S_MARCH;
                        x_q     <= X_INIT_C;
                        y_q     <= Y_INIT_C;
                        alive_q <= COUNT_C;
                        dir_x_q <= 1'b1;
                        dir_y_q <= 1'b0;
                        clr_q   <= 1'b0;
                        over_q  <= 1'b0;
                    end
                end
                S_MARCH: begin
                    alive_q <= alive_d;
                    if (tick) x_q <= x_d;
                    // Last kill wins over a boundary hit on the same frame.
                    if (alive_d == 6'd0) begin
                        state_q <= S_CLEARED;
                        dir_y_q <= 1'b0;
                        clr_q   <= 1'b1;
                        del_q   <= 1'b1;
                    end else if (tick && at_edge) begin
                        state_q    <= S_DROP;
                        dir_y_q    <= 1'b1;
                        drop_cnt_q <= DROP_C;
                    end
                end
                S_DROP: begin
                    alive_q <= alive_d;
                    if (tick) begin
                        y_q        <= y_d;
                        drop_cnt_q <= cnt_d;
                    end
                    // Reaching the limit loses the wave even if the drop also ends
                    // or the last enemy dies on this frame.
                    if (tick && y_d == Y_LIMIT_C) begin
                        state_q <= S_OVER;
                        dir_y_q <= 1'b0;
                        over_q  <= 1'b1;
                        del_q   <= 1'b1;
                    end else if (alive_d == 6'd0) begin
                        state_q <= S_CLEARED;
                        dir_y_q <= 1'b0;
                        clr_q   <= 1'b1;
                        del_q   <= 1'b1;
                    end else if (tick && cnt_d == 10'd0) begin
                        state_q <= S_MARCH;
                        dir_x_q <= ~dir_x_q;
                        dir_y_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.enemy_direction_X = dir_x_q;
    assign bus.enemy_direction_Y = dir_y_q;
    assign bus.delete_enemies    = del_q;
    assign bus.formation_x       = x_q;
    assign bus.formation_y       = y_q;
    assign bus.enemies_alive     = alive_q;
    assign bus.wave_cleared      = clr_q;
    assign bus.game_over         = over_q;
endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Scoreboard bench for enemy_wave_ctrl: stimulus queues expected snapshots and
// delete pulses, a negedge monitor pops and compares them.
module tb_enemy_wave_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    enemy_wave_ctrl_if bus();

    enemy_wave_ctrl dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] x, y;
        logic [5:0] alive;
        logic       dx, dy, wc, go;
    } exp_t;

    typedef struct {
        string tag;
        logic  wc, go;
    } del_t;

    exp_t exp_q[$];
    del_t dexp_q[$];
    exp_t e;
    del_t d;
    int   tests = 0;
    int   fails = 0;
    logic del_prev = 1'b0;

    task automatic chk(input string tag, input string f, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, f, act, expv);
        end
    endtask

    // Monitor: compares queued snapshots and every delete pulse.
    always @(negedge clk) begin
        if (bus.delete_enemies === 1'b1) begin
            if (del_prev) begin
                tests++; fails++;
                $display("FAIL delete_width: pulse longer than one cycle");
            end else if (dexp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL delete_unexpected: pulse with no expected event");
            end else begin
                d = dexp_q.pop_front();
                chk(d.tag, "del_wc", int'(bus.wave_cleared), int'(d.wc));
                chk(d.tag, "del_go", int'(bus.game_over), int'(d.go));
            end
        end
        del_prev = (bus.delete_enemies === 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "x",     int'(bus.formation_x),       int'(e.x));
            chk(e.tag, "y",     int'(bus.formation_y),       int'(e.y));
            chk(e.tag, "alive", int'(bus.enemies_alive),     int'(e.alive));
            chk(e.tag, "dirx",  int'(bus.enemy_direction_X), int'(e.dx));
            chk(e.tag, "diry",  int'(bus.enemy_direction_Y), int'(e.dy));
            chk(e.tag, "clr",   int'(bus.wave_cleared),      int'(e.wc));
            chk(e.tag, "over",  int'(bus.game_over),         int'(e.go));
        end
    end

    task automatic expect_st(input string tag, input int x, input int y, input int alive,
                             input bit dx, input bit dy, input bit wc, input bit go);
        exp_t t;
        t.tag = tag; t.x = 10'(x); t.y = 10'(y); t.alive = 6'(alive);
        t.dx = dx; t.dy = dy; t.wc = wc; t.go = go;
        exp_q.push_back(t);
    endtask

    task automatic expect_del(input string tag, input bit wc, input bit go);
        del_t t;
        t.tag = tag; t.wc = wc; t.go = go;
        dexp_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: tick is live between the 2nd and 3rd edge; optional hit/reset land on it.
    task automatic frame(input bit do_hit, input bit do_rst);
        bus.frame_clk = 1'b1;
        step(); step();
        bus.frame_clk = 1'b0;
        if (do_hit) bus.hit = 1'b1;
        if (do_rst) rst = 1'b1;
        step();
        bus.hit = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) frame(1'b0, 1'b0);
    endtask

    task automatic hit_pulse();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.frame_clk = 1'b0; bus.start = 1'b0; bus.is_playing = 1'b1; bus.hit = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        expect_st("reset", 100, 40, 15, 1, 0, 0, 0);
        step();

        start_pulse();
        expect_st("start", 100, 40, 15, 1, 0, 0, 0);
        step();

        // March right to the edge and drop.
        ticks(132);
        expect_st("right_edge", 232, 40, 15, 1, 1, 0, 0);
        step();
        ticks(10);
        expect_st("drop_done", 232, 50, 15, 0, 0, 0, 0);
        step();
        ticks(223);
        expect_st("left_pre", 9, 50, 15, 0, 0, 0, 0);
        step();
        ticks(1);
        expect_st("left_edge", 8, 50, 15, 0, 1, 0, 0);
        step();
        ticks(3);
        expect_st("mid_drop", 8, 53, 15, 0, 1, 0, 0);
        step();

        // Reset mid-drop with a coincident hit and tick.
        frame(1'b1, 1'b1);
        expect_st("rst_mid_drop", 100, 40, 15, 1, 0, 0, 0);
        step();

        // Clearing the wave; last hit coincides with a tick.
        start_pulse();
        ticks(5);
        expect_st("march5", 105, 40, 15, 1, 0, 0, 0);
        step();
        repeat (14) begin hit_pulse(); step(); end
        expect_st("hits14", 105, 40, 1, 1, 0, 0, 0);
        step();
        expect_del("clear_del", 1'b1, 1'b0);
        frame(1'b1, 1'b0);
        expect_st("cleared", 106, 40, 0, 1, 0, 1, 0);
        step();
        hit_pulse();
        ticks(2);
        expect_st("hit16", 106, 40, 0, 1, 0, 1, 0);
        step();

        // Pause: ticks discarded, then first tick latency after re-enable.
        start_pulse();
        ticks(3);
        expect_st("pre_pause", 103, 40, 15, 1, 0, 0, 0);
        step();
        bus.is_playing = 1'b0;
        ticks(20);
        expect_st("paused", 103, 40, 15, 1, 0, 0, 0);
        step();
        bus.is_playing = 1'b1;
        bus.frame_clk = 1'b1;
        step();
        expect_st("lat1", 103, 40, 15, 1, 0, 0, 0);
        step();
        expect_st("lat2", 103, 40, 15, 1, 0, 0, 0);
        step();
        expect_st("lat3", 104, 40, 15, 1, 0, 0, 0);
        bus.frame_clk = 1'b0;
        step(); step();

        // March down to the limit.
        expect_del("over_del", 1'b0, 1'b1);
        ticks(7859);
        expect_st("pre_over", 8, 379, 15, 0, 1, 0, 0);
        step();
        ticks(1);
        expect_st("over", 8, 380, 15, 0, 0, 0, 1);
        step();
        hit_pulse();
        step();
        expect_st("over_hit", 8, 380, 15, 0, 0, 0, 1);
        step();

        // Restart, then a start during MARCH must be ignored.
        start_pulse();
        expect_st("restart", 100, 40, 15, 1, 0, 0, 0);
        step();
        ticks(1);
        start_pulse();
        step();
        expect_st("start_ignored", 101, 40, 15, 1, 0, 0, 0);
        step(); step(); step();

        chk("drain", "exp_q", exp_q.size(), 0);
        chk("drain", "del_q", dexp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
